lsu_ctrl: RTL

Multi-cycle load/store controller between the execute stage and the data-memory port. It accepts one instruction per transaction and decodes opcode/funct3 from the raw instruction word. For loads and stores it issues a single word-aligned request with byte strobes, then waits for the memory response. It formats load data with sign or zero extension and presents the result to writeback over a valid/ready handshake.

---
 rtl/lsu_ctrl_if.sv | 46 ++++
 rtl/lsu_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// Execute / data-memory / writeback signal bundle for lsu_ctrl.
// out_misalign exists only when LSU_MISALIGN_CHECK_EN is defined.
interface lsu_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_inst;
   logic [ADDR_W-1:0] in_addr;
   logic [31:0]       in_wdata;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_wen;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [31:0]       mem_req_wdata;
   logic [3:0]        mem_req_wstrb;
   logic              mem_resp_valid;
   logic [31:0]       mem_resp_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_rdata;
   logic              out_is_load;
`ifdef LSU_MISALIGN_CHECK_EN
   logic              out_misalign;
`endif

   modport master (
`ifdef LSU_MISALIGN_CHECK_EN
      input  out_misalign,
`endif
      output in_valid, in_inst, in_addr, in_wdata, mem_req_ready,
      output mem_resp_valid, mem_resp_rdata, out_ready,
      input  in_ready, mem_req_valid, mem_req_wen, mem_req_addr,
      input  mem_req_wdata, mem_req_wstrb, out_valid, out_rdata, out_is_load
   );

   modport slave (
`ifdef LSU_MISALIGN_CHECK_EN
      output out_misalign,
`endif
      input  in_valid, in_inst, in_addr, in_wdata, mem_req_ready,
      input  mem_resp_valid, mem_resp_rdata, out_ready,
      output in_ready, mem_req_valid, mem_req_wen, mem_req_addr,
      output mem_req_wdata, mem_req_wstrb, out_valid, out_rdata, out_is_load
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store controller between execute and the data-memory port.
// Optional LSU_MISALIGN_CHECK_EN: misaligned half/word accesses complete without a memory request.
module lsu_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic       clk,
   input logic       rst_n,
   lsu_ctrl_if.slave bus
);
   // state | meaning
   // IDLE  | in_ready high, waiting for an instruction
   // REQ   | memory request held until mem_req_ready
   // WAIT  | waiting for mem_resp_valid
   // DONE  | result held until out_ready
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   state_t            state;
   logic [31:0]       inst_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              in_ready_q, req_valid_q, req_wen_q, out_valid_q, out_is_load_q;
   logic [ADDR_W-1:0] req_addr_q;
   logic [31:0]       req_wdata_q, out_rdata_q;
   logic [3:0]        req_wstrb_q;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_load, is_store;
   logic [3:0]  st_strb;
   logic [31:0] st_wdata, ld_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        unused_bits;

   assign opcode   = bus.in_inst[6:0];
   assign funct3   = bus.in_inst[14:12];
   assign is_load  = (opcode == OP_LOAD) &&
                     (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   assign is_store = (opcode == OP_STORE) && (funct3 inside {3'b000, 3'b001, 3'b010});

   always_comb begin
      st_strb  = 4'b1111;
      st_wdata = bus.in_wdata;
      case (funct3[1:0])
         2'b00: begin
            st_strb  = 4'b0001 << bus.in_addr[1:0];
            st_wdata = {4{bus.in_wdata[7:0]}};
         end
         2'b01: begin
            st_strb  = bus.in_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{bus.in_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load formatting uses the captured funct3/address, not the live inputs.
   always_comb begin
      ld_byte = bus.mem_resp_rdata[{addr_q[1:0], 3'b000} +: 8];
      ld_half = bus.mem_resp_rdata[{addr_q[1], 4'b0000} +: 16];
      case (inst_q[14:12])
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = bus.mem_resp_rdata;
      endcase
   end

`ifdef LSU_MISALIGN_CHECK_EN
   logic mis, misalign_q;
   assign mis = ((funct3[1:0] == 2'b01) && bus.in_addr[0]) ||
                ((funct3[1:0] == 2'b10) && (bus.in_addr[1:0] != 2'b00));
   assign bus.out_misalign = misalign_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         inst_q        <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         in_ready_q    <= 1'b1;
         req_valid_q   <= 1'b0;
         req_wen_q     <= 1'b0;
         req_addr_q    <= '0;
         req_wdata_q   <= '0;
         req_wstrb_q   <= '0;
         out_valid_q   <= 1'b0;
         out_rdata_q   <= '0;
         out_is_load_q <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
         misalign_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               inst_q     <= bus.in_inst;
               addr_q     <= bus.in_addr;
               wdata_q    <= bus.in_wdata;
               in_ready_q <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
               if ((is_load || is_store) && mis) begin
                  state         <= DONE;
                  out_valid_q   <= 1'b1;
                  out_rdata_q   <= '0;
                  out_is_load_q <= is_load;
                  misalign_q    <= 1'b1;
               end else
`endif
               if (is_load || is_store) begin
                  state       <= REQ;
                  req_valid_q <= 1'b1;
                  req_wen_q   <= is_store;
                  req_addr_q  <= {bus.in_addr[ADDR_W-1:2], 2'b00};
                  req_wdata_q <= st_wdata;
                  req_wstrb_q <= is_store ? st_strb : 4'b0000;
               end else begin
                  state         <= DONE;
                  out_valid_q   <= 1'b1;
                  out_rdata_q   <= '0;
                  out_is_load_q <= 1'b0;
               end
            end
            REQ: if (bus.mem_req_ready) begin
               state       <= WAIT;
               req_valid_q <= 1'b0;
            end
            WAIT: if (bus.mem_resp_valid) begin
               state         <= DONE;
               out_valid_q   <= 1'b1;
               out_rdata_q   <= (inst_q[6:0] == OP_LOAD) ? ld_data : 32'h0;
               out_is_load_q <= (inst_q[6:0] == OP_LOAD);
            end
            DONE: if (bus.out_ready) begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
               misalign_q  <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.mem_req_valid = req_valid_q;
   assign bus.mem_req_wen   = req_wen_q;
   assign bus.mem_req_addr  = req_addr_q;
   assign bus.mem_req_wdata = req_wdata_q;
   assign bus.mem_req_wstrb = req_wstrb_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_rdata     = out_rdata_q;
   assign bus.out_is_load   = out_is_load_q;

   assign unused_bits = ^{inst_q[31:15], inst_q[11:7], addr_q[ADDR_W-1:2], wdata_q};
endmodule
